// File: rtl/seven_seg_capture_if.sv
// Scan bus of the 8-digit seven-segment display: active-low anode strobes plus the shared digit value.
interface seven_seg_capture_if;
  logic [7:0] an;
  logic [3:0] ONE_DIGIT;

  modport master (output an, output ONE_DIGIT);
  modport slave  (input  an, input  ONE_DIGIT);
endinterface

// File: rtl/seven_seg_capture.sv
// Receive side of the seven-segment scan: waits for each strobe/digit pair to settle,
// then rebuilds digit1..digit8 and reports frame completion, bad strobes and stalled scans.
module seven_seg_capture #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  seven_seg_capture_if.slave scan,
  output logic [3:0]         digit1,
  output logic [3:0]         digit2,
  output logic [3:0]         digit3,
  output logic [3:0]         digit4,
  output logic [3:0]         digit5,
  output logic [3:0]         digit6,
  output logic [3:0]         digit7,
  output logic [3:0]         digit8,
  output logic               frame_valid,
  output logic               scan_error,
  output logic               stall
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [7:0]    an_q, an_p;
  logic [3:0]    d_q, d_p;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] stall_cnt;
  logic [3:0]    digit_r [8];
  logic [7:0]    seen;

  logic       pair_match;
  logic       capture;
  logic       one_cold;
  logic       multi;
  logic [7:0] sel;
  logic [7:0] seen_next;

  always_comb begin
    pair_match = (an_q == an_p) && (d_q == d_p);
    // Count only ever passes SETTLE-1 once per dwell, so this yields a single capture.
    capture    = pair_match && (settle_cnt == SW'(SETTLE - 1));
    sel        = ~an_q;
    one_cold   = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    multi      = (sel != 8'h00) && !one_cold;
    seen_next  = seen | sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q <= '1;
      d_q  <= '0;
      an_p <= '1;
      d_p  <= '0;
    end else begin
      an_q <= scan.an;
      d_q  <= scan.ONE_DIGIT;
      an_p <= an_q;
      d_p  <= d_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= '0;
    end else if (!pair_match) begin
      settle_cnt <= '0;
    end else if (settle_cnt != SW'(SETTLE)) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Strobe-only activity counter: digit bus changes do not keep the scan alive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (an_q != an_p) begin
      stall_cnt <= '0;
    end else if (stall_cnt != TW'(TIMEOUT)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) digit_r[i] <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      scan_error  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      scan_error  <= 1'b0;
      if (capture) begin
        if (one_cold) begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (sel[i]) digit_r[i] <= d_q;
          end
          if (seen_next == 8'hFF) begin
            frame_valid <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= seen_next;
          end
        end else if (multi) begin
          scan_error <= 1'b1;
        end
      end
    end
  end

  assign stall  = (stall_cnt == TW'(TIMEOUT));
  assign digit1 = digit_r[0];
  assign digit2 = digit_r[1];
  assign digit3 = digit_r[2];
  assign digit4 = digit_r[3];
  assign digit5 = digit_r[4];
  assign digit6 = digit_r[5];
  assign digit7 = digit_r[6];
  assign digit8 = digit_r[7];

endmodule

// File: tb/tb_seven_seg_capture.sv
// Randomised bench for seven_seg_capture: a sample-history reference model predicts every
// output after each clock, with directed scans, glitches, bad strobes, stalls and resets.
module tb_seven_seg_capture;

  localparam int S = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_seg_capture_if bus ();

  logic [3:0] digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8;
  logic       frame_valid, scan_error, stall;

  seven_seg_capture #(.SETTLE(S), .TIMEOUT(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan        (bus),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit4      (digit4),
    .digit5      (digit5),
    .digit6      (digit6),
    .digit7      (digit7),
    .digit8      (digit8),
    .frame_valid (frame_valid),
    .scan_error  (scan_error),
    .stall       (stall)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: run lengths of identical pin samples decide captures and stall.
  logic [7:0] last_an;
  logic [3:0] last_d;
  int         run_pair, run_an;
  logic       pend;
  logic [7:0] pend_an;
  logic [3:0] pend_d;
  logic [3:0] m_digit [8];
  logic [7:0] m_seen;
  logic       exp_fv, exp_err, exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      passed++;
  endtask

  task automatic model_reset();
    // Reset leaves the input registers holding FF/0 with both counters at zero.
    last_an  = 8'hFF;
    last_d   = 4'h0;
    run_pair = 2;
    run_an   = 2;
    pend     = 1'b0;
    for (int i = 0; i < 8; i++) m_digit[i] = 4'h0;
    m_seen    = 8'h00;
    exp_fv    = 1'b0;
    exp_err   = 1'b0;
    exp_stall = 1'b0;
  endtask

  task automatic check_all(input string ph);
    logic [3:0] got [8];
    got = '{digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8};
    for (int i = 0; i < 8; i++)
      check($sformatf("%s digit%0d", ph, i + 1), 32'(got[i]), 32'(m_digit[i]));
    check({ph, " frame_valid"}, 32'(frame_valid), 32'(exp_fv));
    check({ph, " scan_error"},  32'(scan_error),  32'(exp_err));
    check({ph, " stall"},       32'(stall),       32'(exp_stall));
  endtask

  task automatic step(input string ph, input logic [7:0] a, input logic [3:0] d);
    int zeros;
    bus.an        = a;
    bus.ONE_DIGIT = d;
    @(posedge clk);
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    if (pend) begin
      zeros = $countones(~pend_an);
      if (zeros == 1) begin
        for (int i = 0; i < 8; i++) begin
          if (!pend_an[i]) begin
            m_digit[i] = pend_d;
            m_seen[i]  = 1'b1;
          end
        end
        if (m_seen == 8'hFF) begin
          exp_fv = 1'b1;
          m_seen = 8'h00;
        end
      end else if (zeros > 1) begin
        exp_err = 1'b1;
      end
    end
    exp_stall = (run_an >= T + 1);
    run_an   = (a == last_an) ? ((run_an < 100000) ? run_an + 1 : run_an) : 1;
    run_pair = (a == last_an && d == last_d) ? ((run_pair < 100000) ? run_pair + 1 : run_pair) : 1;
    pend     = (run_pair == S + 1);
    pend_an  = a;
    pend_d   = d;
    last_an  = a;
    last_d   = d;
    #1;
    check_all(ph);
  endtask

  task automatic hold(input string ph, input logic [7:0] a, input logic [3:0] d, input int n);
    for (int k = 0; k < n; k++) step(ph, a, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic scan_random_order(input string ph);
    int         order [8];
    int         j, tmp;
    logic [7:0] a;
    for (int i = 0; i < 8; i++) order[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 8; i++) begin
      a = ~(8'h01 << order[i]);
      hold(ph, a, 4'($urandom), $urandom_range(10, 6));
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [3:0] d;
    int         sel, len;

    model_reset();
    bus.an        = 8'hFF;
    bus.ONE_DIGIT = 4'h0;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      a = ~(8'h01 << i);
      hold("scan", a, 4'(i), 8);
    end
    hold("scan_tail", 8'hFF, 4'h0, 4);

    hold("glitch_pre", 8'hFD, 4'h1, 8);
    hold("glitch", 8'hFD, 4'h9, 3);
    hold("glitch_post", 8'hFD, 4'h1, 8);

    hold("bad_strobe", 8'hFC, 4'h5, 10);

    hold("stall", 8'hFE, 4'h3, 20);
    hold("stall_clear", 8'hFD, 4'h3, 3);

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(9, 0);
      if (sel < 7) a = ~(8'h01 << $urandom_range(7, 0));
      else if (sel == 7) a = 8'hFF;
      else a = 8'($urandom);
      d   = 4'($urandom);
      len = ($urandom_range(9, 0) == 0) ? $urandom_range(24, 15) : $urandom_range(8, 1);
      hold("random", a, d, len);
    end

    for (int i = 0; i < 5; i++) begin
      a = ~(8'h01 << i);
      hold("partial", a, 4'(i + 8), 7);
    end
    do_reset();
    scan_random_order("after_reset");
    hold("after_reset_tail", 8'hFF, 4'h0, 4);
    scan_random_order("second_frame");
    hold("second_frame_tail", 8'hFF, 4'h0, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
